vga_tile_renderer: RTL and testbench
====================================

VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset named `clk` and `rst`, with polarity and synchronicity fixed.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- H_ACTIVE 640, visible pixels per line
- H_FP 16, horizontal front porch
- H_SYNC 96, hsync width
- H_BP 48, horizontal back porch
- V_ACTIVE 480, visible lines
- V_FP 10, vertical front porch
- V_SYNC 2, vsync width
- V_BP 29, vertical back porch
- SYNC_POL 0, sync active level (0 = active-low)
- TILE_SHIFT 4, log2 of tile edge in pixels
- BOARD_W 40, board tiles per row
- BOARD_H 30, board tile rows
- BORDER_RGB 8'h00, colour for visible pixels outside the board
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- pix_en, in, 1, pixel strobe; all state advances only when high
- board_x, out, 6, tile column address to board memory
- board_y, out, 6, tile row address to board memory
- board_data, in, 3, tile code, valid one pix_en after address
- tile_state, out, 3, registered tile code for the graphics lookup
- tile_rel_x, out, TILE_SHIFT, pixel column within tile
- tile_rel_y, out, TILE_SHIFT, pixel row within tile
- sprite_rgb, in, 8, combinational graphics colour {b[1:0],g[2:0],r[2:0]}
- red, out, 3, colour
- green, out, 3, colour
- blue, out, 2, colour
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- frame_start, out, 1, one-clk pulse with the first visible pixel of each frame

Function
REQ-004 Counters hc (0..H_ACTIVE+H_FP+H_SYNC+H_BP-1) and vc (0..V_ACTIVE+V_FP+V_SYNC+V_BP-1) SHALL advance only on pix_en; hc wraps to 0 and increments vc, and vc wraps to 0 after its last line.
REQ-005 Counter value 0 SHALL be the first visible pixel; the active region is hc<H_ACTIVE and vc<V_ACTIVE.
REQ-006 Raw sync SHALL be active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, and likewise for vc, with active level SYNC_POL.
REQ-007 Stage 1 (on pix_en) SHALL register board_x = hc>>TILE_SHIFT, board_y = vc>>TILE_SHIFT, the low TILE_SHIFT bits of hc and vc, active, in_board, and raw syncs.
- in_board = active, board_x<BOARD_W, and board_y<BOARD_H.
- board_x and board_y are forced to 0 when not in_board.
REQ-008 Stage 2 (on pix_en) SHALL register tile_state = board_data (0 when stage-1 in_board is low), tile_rel_x/tile_rel_y, and the delayed flags.
REQ-009 Stage 3 (on pix_en) SHALL register the outputs as follows:
- {blue,green,red} = sprite_rgb if in_board; BORDER_RGB if active but not in_board; 0 if not active.
- hsync and vsync are the 3-stage-delayed raw syncs.
REQ-010 Latency from counter value to red/green/blue/hsync/vsync SHALL be exactly 3 pix_en strobes, and all outputs SHALL stay mutually aligned.
REQ-011 frame_start SHALL pulse high for exactly one clk, coincident with the stage-3 update whose pixel has hc=0 and vc=0.
REQ-012 While pix_en is low, every register SHALL hold its value and frame_start SHALL be 0.
REQ-013 Widths: board_x/board_y SHALL truncate to 6 bits, and parameter sets with BOARD_W or BOARD_H > 64 are unsupported.

Reset
REQ-014 On rst, the block SHALL set:
- hc and vc to 0
- all pipeline flags inactive
- board_x, board_y, tile_state, tile_rel_x, tile_rel_y, red, green, blue, frame_start to 0
- hsync and vsync to ~SYNC_POL
REQ-015 rst SHALL override pix_en, and asserting rst mid-frame SHALL restart the frame at hc=vc=0.
REQ-016 After reset, the first frame_start SHALL follow the 3rd pix_en strobe.

Verification
REQ-017 Reset: assert rst 2 clks with pix_en=1, then release -> outputs are the REQ-014 values until strobe 3; frame_start pulses on strobe 3.
REQ-018 Sync timing at defaults, pix_en=1 -> hsync low for 96 strobes starting at strobe 659 after reset and repeating every 800; vsync low for 2 lines starting at line 490 and repeating every 521 lines.
REQ-019 Latency: model board memory as registered (code = board_x[2:0]) and sprite_rgb = {5'b0,tile_state} -> pixel at hc=32 shows red=2 exactly 3 strobes after hc=32.
REQ-020 Border: BOARD_W=30, BORDER_RGB=8'hFF -> hc 480..639 output 8'hFF and board_x=0; blanking outputs 0.
REQ-021 Throttle: pix_en high every 4th clk -> identical output sequence per strobe as the pix_en=1 run; frame_start is one clk wide.
REQ-022 Reset mid-frame: assert rst at vc=200, hc=300 -> counters restart at 0 and frame_start recurs 3 strobes after release.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: VGA timing generator feeding a 3-stage tile-map pixel pipeline
// (address -> tile fetch -> colour), all state advancing on pix_en.
module vga_tile_renderer #(
   parameter int         H_ACTIVE   = 640,
   parameter int         H_FP       = 16,
   parameter int         H_SYNC     = 96,
   parameter int         H_BP       = 48,
   parameter int         V_ACTIVE   = 480,
   parameter int         V_FP       = 10,
   parameter int         V_SYNC     = 2,
   parameter int         V_BP       = 29,
   parameter bit         SYNC_POL   = 1'b0,
   parameter int         TILE_SHIFT = 4,
   parameter int         BOARD_W    = 40,
   parameter int         BOARD_H    = 30,
   parameter logic [7:0] BORDER_RGB = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   output logic [5:0]            board_x,
   output logic [5:0]            board_y,
   input  logic [2:0]            board_data,
   output logic [2:0]            tile_state,
   output logic [TILE_SHIFT-1:0] tile_rel_x,
   output logic [TILE_SHIFT-1:0] tile_rel_y,
   input  logic [7:0]            sprite_rgb,
   output logic [2:0]            red,
   output logic [2:0]            green,
   output logic [1:0]            blue,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HA     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS0    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS1    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BW     = HW'(BOARD_W);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VA     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS0    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS1    = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] BH     = VW'(BOARD_H);

   logic [HW-1:0] hc, bx_w;
   logic [VW-1:0] vc, by_w;
   logic act, inb, hs_raw, vs_raw;
   logic act1, inb1, hs1, vs1, fs1;
   logic act2, inb2, hs2, vs2, fs2;
   logic [TILE_SHIFT-1:0] rx1, ry1;

   // Sync flags travel the pipeline as "active" booleans; polarity is applied at the output.
   assign bx_w   = hc >> TILE_SHIFT;
   assign by_w   = vc >> TILE_SHIFT;
   assign act    = (hc < HA) && (vc < VA);
   assign inb    = act && (bx_w < BW) && (by_w < BH);
   assign hs_raw = (hc >= HS0) && (hc < HS1);
   assign vs_raw = (vc >= VS0) && (vc < VS1);

   always_ff @(posedge clk) begin
      if (rst) begin
         hc          <= '0;
         vc          <= '0;
         {act1, inb1, hs1, vs1, fs1} <= '0;
         {act2, inb2, hs2, vs2, fs2} <= '0;
         board_x     <= '0;
         board_y     <= '0;
         rx1         <= '0;
         ry1         <= '0;
         tile_state  <= '0;
         tile_rel_x  <= '0;
         tile_rel_y  <= '0;
         {blue, green, red} <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en & fs2;
         if (pix_en) begin
            hc <= (hc == H_LAST) ? '0 : hc + 1'b1;
            if (hc == H_LAST) vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            board_x    <= inb ? 6'(bx_w) : 6'd0;
            board_y    <= inb ? 6'(by_w) : 6'd0;
            rx1        <= hc[TILE_SHIFT-1:0];
            ry1        <= vc[TILE_SHIFT-1:0];
            act1       <= act;
            inb1       <= inb;
            hs1        <= hs_raw;
            vs1        <= vs_raw;
            fs1        <= (hc == '0) && (vc == '0);
            tile_state <= inb1 ? board_data : 3'd0;
            tile_rel_x <= rx1;
            tile_rel_y <= ry1;
            act2       <= act1;
            inb2       <= inb1;
            hs2        <= hs1;
            vs2        <= vs1;
            fs2        <= fs1;
            {blue, green, red} <= inb2 ? sprite_rgb : act2 ? BORDER_RGB : 8'h00;
            hsync      <= hs2 ? SYNC_POL : ~SYNC_POL;
            vsync      <= vs2 ? SYNC_POL : ~SYNC_POL;
         end
      end
   end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: scoreboard bench on a scaled-down timing set so full frames fit the cycle budget.
module tb_vga_tile_renderer;
   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 32, VFP = 2, VS = 2, VBP = 3;
   localparam int TS = 3, BW = 6, BH = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;

   typedef struct packed {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0, pix_en = 1'b0;
   logic [5:0] board_x, board_y;
   logic [2:0] board_data = 3'd0, tile_state;
   logic [TS-1:0] tile_rel_x, tile_rel_y;
   logic [7:0] sprite_rgb;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic hsync, vsync, frame_start;

   exp_t q[$];
   int vectors = 0, errors = 0;
   int mh = 0, mv = 0;
   localparam exp_t RST = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, fs: 1'b0};

   always #5 clk = ~clk;

   vga_tile_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(1'b0), .TILE_SHIFT(TS), .BOARD_W(BW), .BOARD_H(BH),
      .BORDER_RGB(8'hFF)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .board_x(board_x), .board_y(board_y), .board_data(board_data),
      .tile_state(tile_state), .tile_rel_x(tile_rel_x), .tile_rel_y(tile_rel_y),
      .sprite_rgb(sprite_rgb), .red(red), .green(green), .blue(blue),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
   );

   // Registered board memory, read on the falling edge so the code is ready by the next strobe.
   always_ff @(negedge clk) board_data <= board_x[2:0] ^ board_y[2:0];
   assign sprite_rgb = {tile_rel_y[1:0], tile_rel_x, tile_state};

   function automatic exp_t pix(int h, int v);
      exp_t e;
      bit act, inb;
      int bx, by;
      act = (h < HA) && (v < VA);
      bx = h >> TS;
      by = v >> TS;
      inb = act && (bx < BW) && (by < BH);
      e.rgb = inb ? {2'(v % 8), 3'(h % 8), 3'(bx ^ by)} : act ? 8'hFF : 8'h00;
      e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.fs = (h == 0) && (v == 0);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at h=%0d v=%0d: got %0h expected %0h", tag, mh, mv, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pix_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pix_en = 1'b0;
      chk("rst_rgb", 32'({blue, green, red}), 32'(RST.rgb));
      chk("rst_hsync", 32'(hsync), 32'(RST.hs));
      chk("rst_vsync", 32'(vsync), 32'(RST.vs));
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_bxy", 32'({board_x, board_y}), 0);
      chk("rst_tile", 32'({tile_state, tile_rel_x, tile_rel_y}), 0);
      mh = 0;
      mv = 0;
      q.delete();
      q.push_back(RST);
      q.push_back(RST);
   endtask

   task automatic strobe(int gap);
      exp_t e;
      int bx, by;
      bit inb;
      q.push_back(pix(mh, mv));
      bx = mh >> TS;
      by = mv >> TS;
      inb = (mh < HA) && (mv < VA) && (bx < BW) && (by < BH);
      pix_en = 1'b1;
      @(posedge clk);
      #1 pix_en = (gap == 0);
      e = q.pop_front();
      chk("rgb", 32'({blue, green, red}), 32'(e.rgb));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("board_xy", 32'({board_x, board_y}), inb ? 32'({6'(bx), 6'(by)}) : 0);
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk);
         #1;
         chk("idle_fs", 32'(frame_start), 0);
         chk("idle_hold", 32'({blue, green, red, hsync, vsync}), 32'({e.rgb, e.hs, e.vs}));
      end
   endtask

   initial begin
      do_reset();
      repeat (HT * VT + 200) strobe(0);
      do_reset();
      repeat (HT * VT + 10) strobe(3);
      do_reset();
      while (!(mh == 30 && mv == 20)) strobe(0);
      do_reset();
      repeat (100) strobe(0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
